// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serializer_pkg
// Description : Shared types and default constants for the sample serializer.
//               Holds the frame state encoding and the default shift-word
//               width and sclk divider ratio.
// Revision    : 1.0 - initial release
// ============================================================================
package serializer_pkg;

  localparam int unsigned c_default_width  = 51;
  localparam int unsigned c_default_clkdiv = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/sample_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : sample_serializer_if
// Description : Parallel word handshake between a word producer and the
//               sample serializer.
// Signals     : word_in   - parallel word to transmit (WIDTH bits)
//               valid_in  - word_in valid
//               ready_out - serializer can accept a word
// Modports    : master (producer side), slave (serializer side)
// Revision    : 1.0 - initial release
// ============================================================================
interface sample_serializer_if
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH = c_default_width
);

  logic [WIDTH-1:0] word_in;
  logic             valid_in;
  logic             ready_out;

  modport master (
    output word_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  word_in,
    input  valid_in,
    output ready_out
  );

endinterface
`default_nettype wire

// File: rtl/clk_en_div.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_div
// Description : Clock-enable divider. While en is high a counter runs
//               0..CLKDIV-1 and tick is high during the cycle in which it
//               wraps. While en is low the counter is held at zero, so every
//               enabled period starts a full CLKDIV count from scratch.
// Ports       : clk     - clock
//               reset_n - asynchronous active-low reset
//               en      - count enable
//               tick    - one-cycle pulse on the wrap cycle
// Revision    : 1.0 - initial release
// ============================================================================
module clk_en_div
  import serializer_pkg::*;
#(
  parameter int unsigned CLKDIV = c_default_clkdiv
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned          c_cnt_w = $clog2(CLKDIV + 1);
  localparam logic [c_cnt_w-1:0]   c_max   = c_cnt_w'(CLKDIV - 1);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q == c_max) begin
        tick = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sample_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sample_serializer
// Description : Parallel-to-serial word transmitter. A word accepted on the
//               handshake is shifted out MSB first on sdata, framed by cs_n
//               low, with sclk running at clk / (2*CLKDIV). Each frame is
//               followed by a CLKDIV-cycle gap and a one-cycle done pulse.
// Ports       : clk     - clock, rising edge
//               reset_n - asynchronous active-low reset
//               bus     - word_in / valid_in / ready_out handshake (slave)
//               sclk    - serial bit clock, idles low
//               sdata   - serial data, MSB first, stable across sclk rise
//               cs_n    - frame enable, low while a word is on the wire
//               done    - one-cycle pulse in the IDLE cycle after the gap
// Revision    : 1.0 - initial release
// ============================================================================
module sample_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH  = c_default_width,
  parameter int unsigned CLKDIV = c_default_clkdiv
) (
  input  logic                clk,
  input  logic                reset_n,
  sample_serializer_if.slave  bus,
  output logic                sclk,
  output logic                sdata,
  output logic                cs_n,
  output logic                done
);

  localparam int unsigned        c_bit_w    = $clog2(WIDTH + 1);
  localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(WIDTH);

  ser_state_e         state_q,   state_d;
  logic [WIDTH-1:0]   shreg_q,   shreg_d;
  logic [c_bit_w-1:0] bit_cnt_q, bit_cnt_d;
  logic               sclk_q,    sclk_d;
  logic               cs_n_q,    cs_n_d;
  logic               ready_q,   ready_d;
  logic               done_q,    done_d;

  logic               div_en;
  logic               div_tick;

  assign div_en = (state_q != IDLE);

  clk_en_div #(
    .CLKDIV (CLKDIV)
  ) u_clk_en_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (div_en),
    .tick    (div_tick)
  );

  // sdata is taken straight from the shift register MSB. The register is
  // loaded on the handshake, shifted on every falling sclk, and after WIDTH
  // shifts it is all zeros, so sdata is naturally 0 outside a frame.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    ready_d   = ready_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        sclk_d    = 1'b0;
        cs_n_d    = 1'b1;
        ready_d   = 1'b1;
        if (bus.valid_in && ready_q) begin
          state_d = SHIFT;
          shreg_d = bus.word_in;
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
        end
      end

      SHIFT: begin
        if (div_tick) begin
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising sclk: count the bit, data is left untouched.
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            // Falling sclk: present the next bit.
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            if (bit_cnt_q == c_last_bit) begin
              state_d = GAP;
              cs_n_d  = 1'b1;
            end
          end
        end
      end

      GAP: begin
        if (div_tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign bus.ready_out = ready_q;
  assign sclk          = sclk_q;
  assign sdata         = shreg_q[WIDTH-1];
  assign cs_n          = cs_n_q;
  assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_serializer
// Description : Self-checking bench for sample_serializer. Three instances
//               (8/2, default 51/4, 2/1) share clock and reset. Expected
//               serial bits are queued when a word is handed over and popped
//               on each rising sclk inside a frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_serializer;
  import serializer_pkg::*;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- instances ----------------
  sample_serializer_if #(.WIDTH(8)) if8 ();
  logic sc8, sd8, cs8, dn8;
  sample_serializer #(.WIDTH(8), .CLKDIV(2)) u8 (
    .clk(clk), .reset_n(reset_n), .bus(if8),
    .sclk(sc8), .sdata(sd8), .cs_n(cs8), .done(dn8));

  sample_serializer_if #(.WIDTH(c_default_width)) if51 ();
  logic sc51, sd51, cs51, dn51;
  sample_serializer u51 (
    .clk(clk), .reset_n(reset_n), .bus(if51),
    .sclk(sc51), .sdata(sd51), .cs_n(cs51), .done(dn51));

  sample_serializer_if #(.WIDTH(2)) if2 ();
  logic sc2, sd2, cs2, dn2;
  sample_serializer #(.WIDTH(2), .CLKDIV(1)) u2 (
    .clk(clk), .reset_n(reset_n), .bus(if2),
    .sclk(sc2), .sdata(sd2), .cs_n(cs2), .done(dn2));

  // ---------------- monitors ----------------
  bit q8[$], q51[$], q2[$];

  logic p_sc8 = 1'b0, p_cs8 = 1'b1;
  int lo8 = 0, lo8_last = 0, hi8 = 0, gap8_last = 0, rise8 = 0, rise8_last = 0;
  int done8 = 0, sclkhi8 = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (!cs8 && p_cs8) begin
        gap8_last = hi8; hi8 = 0; lo8 = 0; rise8 = 0;
      end
      if (cs8 && !p_cs8) begin
        lo8_last = lo8; rise8_last = rise8; hi8 = 0;
      end
      if (!cs8 && sc8 && !p_sc8) begin
        rise8++;
        if (q8.size() == 0) chk("sb8_empty", 1, 0);
        else chk("sdata8", sd8, q8.pop_front());
      end
      if (!cs8) lo8++; else hi8++;
      if (dn8) begin
        done8++;
        chk("done_ready8", if8.ready_out, 1);
      end
      if (sc8) sclkhi8++;
    end
    p_sc8 = sc8;
    p_cs8 = cs8;
  end

  logic p_sc51 = 1'b0, p_cs51 = 1'b1;
  int lo51 = 0, lo51_last = 0, rise51 = 0, rise51_last = 0, done51 = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (!cs51 && p_cs51) begin lo51 = 0; rise51 = 0; end
      if (cs51 && !p_cs51) begin lo51_last = lo51; rise51_last = rise51; end
      if (!cs51 && sc51 && !p_sc51) begin
        rise51++;
        if (q51.size() == 0) chk("sb51_empty", 1, 0);
        else chk("sdata51", sd51, q51.pop_front());
      end
      if (!cs51) lo51++;
      if (dn51) done51++;
    end
    p_sc51 = sc51;
    p_cs51 = cs51;
  end

  logic p_sc2 = 1'b0, p_cs2 = 1'b1;
  int lo2 = 0, lo2_last = 0, rise2 = 0, rise2_last = 0, done2 = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (!cs2 && p_cs2) begin lo2 = 0; rise2 = 0; end
      if (cs2 && !p_cs2) begin lo2_last = lo2; rise2_last = rise2; end
      // With CLKDIV=1 sclk must flip on every clk cycle inside a frame.
      if (!cs2 && !p_cs2) chk("toggle2", sc2 ^ p_sc2, 1);
      if (!cs2 && sc2 && !p_sc2) begin
        rise2++;
        if (q2.size() == 0) chk("sb2_empty", 1, 0);
        else chk("sdata2", sd2, q2.pop_front());
      end
      if (!cs2) lo2++;
      if (dn2) done2++;
    end
    p_sc2 = sc2;
    p_cs2 = cs2;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send8(input logic [7:0] w, input bit hold);
    int n = 0;
    @(negedge clk);
    if8.word_in  = w;
    if8.valid_in = 1'b1;
    while (!if8.ready_out && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("hs8_timeout", 0, 1);
    else for (int i = 7; i >= 0; i--) q8.push_back(w[i]);
    @(posedge clk);
    #1;
    if (!hold) if8.valid_in = 1'b0;
  endtask

  task automatic send51(input logic [50:0] w);
    int n = 0;
    @(negedge clk);
    if51.word_in  = w;
    if51.valid_in = 1'b1;
    while (!if51.ready_out && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("hs51_timeout", 0, 1);
    else for (int i = 50; i >= 0; i--) q51.push_back(w[i]);
    @(posedge clk);
    #1;
    if51.valid_in = 1'b0;
  endtask

  task automatic send2(input logic [1:0] w);
    int n = 0;
    @(negedge clk);
    if2.word_in  = w;
    if2.valid_in = 1'b1;
    while (!if2.ready_out && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("hs2_timeout", 0, 1);
    else for (int i = 1; i >= 0; i--) q2.push_back(w[i]);
    @(posedge clk);
    #1;
    if2.valid_in = 1'b0;
  endtask

  function automatic int done_count(input int which);
    case (which)
      8:       return done8;
      51:      return done51;
      default: return done2;
    endcase
  endfunction

  task automatic wait_done(input int which, input int budget, input string tag);
    int d0 = done_count(which);
    int n  = 0;
    while (done_count(which) == d0 && n < budget) begin @(negedge clk); n++; end
    chk(tag, (done_count(which) != d0), 1);
  endtask

  // ---------------- test sequence ----------------
  int d;
  int s0;
  int n;

  initial begin
    if8.word_in = '0;  if8.valid_in = 1'b0;
    if51.word_in = '0; if51.valid_in = 1'b0;
    if2.word_in = '0;  if2.valid_in = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_ready", if8.ready_out, 1);
    chk("rst_cs_n",  cs8, 1);
    chk("rst_sclk",  sc8, 0);
    chk("rst_sdata", sd8, 0);
    chk("rst_done",  dn8, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 on the 8/2 instance
    d = done8;
    send8(8'hA5, 1'b0);
    wait_done(8, 200, "a5_done_seen");
    chk("a5_cs_low",  lo8_last, 32);
    chk("a5_rises",   rise8_last, 8);
    chk("a5_done_cnt", done8 - d, 1);
    repeat (3) @(negedge clk);
    chk("idle_sdata", sd8, 0);
    chk("idle_cs_n",  cs8, 1);
    chk("idle_ready", if8.ready_out, 1);
    chk("idle_done",  dn8, 0);

    // back-to-back with valid held high
    d = done8;
    send8(8'h3C, 1'b1);
    send8(8'hC3, 1'b0);
    wait_done(8, 200, "b2b_done_seen");
    chk("b2b_gap",      gap8_last, 3);
    chk("b2b_cs_low",   lo8_last, 32);
    chk("b2b_done_cnt", done8 - d, 2);
    chk("b2b_q_empty",  q8.size(), 0);

    // valid pulse with 0xFF during a 0x00 frame must be ignored
    d = done8;
    send8(8'h00, 1'b0);
    repeat (10) @(negedge clk);
    chk("ign_ready_a", if8.ready_out, 0);
    if8.word_in  = 8'hFF;
    if8.valid_in = 1'b1;
    @(negedge clk);
    if8.valid_in = 1'b0;
    chk("ign_ready_b", if8.ready_out, 0);
    wait_done(8, 200, "ign_done_seen");
    repeat (6) @(negedge clk);
    chk("ign_no_frame", cs8, 1);
    chk("ign_done_cnt", done8 - d, 1);
    chk("ign_cs_low",   lo8_last, 32);

    // default 51/4, only bit 0 set
    d = done51;
    send51(51'd1);
    wait_done(51, 1000, "w51_done_seen");
    chk("w51_cs_low",   lo51_last, 408);
    chk("w51_rises",    rise51_last, 51);
    chk("w51_done_cnt", done51 - d, 1);

    // 2/1, word 2'b10
    d = done2;
    send2(2'b10);
    wait_done(2, 50, "w2_done_seen");
    chk("w2_cs_low",   lo2_last, 4);
    chk("w2_rises",    rise2_last, 2);
    chk("w2_done_cnt", done2 - d, 1);

    // reset after 3 rising sclk of a frame
    send8(8'hA5, 1'b0);
    n = 0;
    while (rise8 < 3 && n < 100) begin @(negedge clk); n++; end
    chk("rst3_reached", (rise8 >= 3), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cs_n",  cs8, 1);
    chk("mid_rst_sclk",  sc8, 0);
    chk("mid_rst_sdata", sd8, 0);
    chk("mid_rst_ready", if8.ready_out, 1);
    chk("mid_rst_done",  dn8, 0);
    q8.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    s0 = sclkhi8;
    repeat (40) @(negedge clk);
    chk("post_rst_sclk",  sclkhi8 - s0, 0);
    chk("post_rst_cs_n",  cs8, 1);
    chk("post_rst_ready", if8.ready_out, 1);

    // a fresh frame after reset is complete and correct
    d = done8;
    send8(8'h5A, 1'b0);
    wait_done(8, 200, "post_done_seen");
    chk("post_cs_low",   lo8_last, 32);
    chk("post_done_cnt", done8 - d, 1);

    chk("q8_empty",  q8.size(), 0);
    chk("q51_empty", q51.size(), 0);
    chk("q2_empty",  q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sample_serializer.md
SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 51, sample/shift-word width in bits (legal 2..64).
REQ-002 SHALL have parameter CLKDIV, default 4, clk cycles per sclk half-period (legal 1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port word_in  input  WIDTH  parallel word to transmit.
REQ-006 SHALL have port valid_in  input  1  word_in valid.
REQ-007 SHALL have port ready_out  output  1  block can accept a word.
REQ-008 SHALL have port sclk  output  1  serial bit clock, idles low.
REQ-009 SHALL have port sdata  output  1  serial data, MSB first.
REQ-010 SHALL have port cs_n  output  1  frame enable, low while a word is on the wire.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of each frame.

Function
REQ-012 SHALL implement states IDLE, SHIFT, GAP.
REQ-013 IDLE: ready_out=1, cs_n=1, sclk=0, sdata=0, divider and bit counter held at 0.
REQ-014 Handshake occurs on a clk edge where valid_in=1 and ready_out=1; word_in is captured into an internal WIDTH-bit register on that edge.
REQ-015 On the handshake edge: state->SHIFT, cs_n->0, ready_out->0, sdata->word_in[WIDTH-1].
REQ-016 valid_in while ready_out=0 SHALL be ignored; word_in is not sampled outside the handshake.
REQ-017 In SHIFT a divider counts 0..CLKDIV-1; on each wrap sclk toggles.
REQ-018 On each sclk 0->1 transition the bit counter increments; sdata SHALL be stable across it.
REQ-019 On each sclk 1->0 transition the register left-shifts by one, zero-filling the LSB, and sdata updates to the new MSB.
REQ-020 After the WIDTH-th rising sclk and its following falling sclk, state->GAP; cs_n->1 and sdata->0 on that edge.
REQ-021 cs_n SHALL be low for exactly 2*WIDTH*CLKDIV clk cycles per frame.
REQ-022 GAP SHALL last CLKDIV clk cycles with cs_n=1, sclk=0, ready_out=0, then state->IDLE.
REQ-023 done SHALL be 1 for exactly the one cycle in which state is IDLE immediately after GAP.
REQ-024 A word may be accepted in that same cycle (done=1 and ready_out=1); back-to-back frames are separated by exactly CLKDIV+1 cs_n-high cycles.
REQ-025 Bit counter width SHALL be $clog2(WIDTH+1); divider width $clog2(CLKDIV+1); no overflow is permitted.
REQ-026 CLKDIV=1 SHALL toggle sclk every clk cycle in SHIFT, with all other rules unchanged.

Reset
REQ-027 reset_n=0 SHALL immediately force state=IDLE, ready_out=1, cs_n=1, sclk=0, sdata=0, done=0, counters and shift register to 0.
REQ-028 Reset mid-frame SHALL abort the frame with no trailing sclk edge; the first frame after release begins only on a new handshake.

Structure
REQ-029 State enum (IDLE, SHIFT, GAP) and default WIDTH/CLKDIV constants SHALL live in shared package serializer_pkg.
REQ-030 Divider SHALL be a sub-module clk_en_div producing a one-cycle tick at each wrap, enabled only in SHIFT and GAP.
REQ-031 All outputs SHALL be registered; no combinational path from valid_in to any output except ready_out-independent state.

Verification
REQ-032 WIDTH=8, CLKDIV=2, word 0xA5 -> sdata sampled on rising sclk reads 1,0,1,0,0,1,0,1; cs_n low 32 cycles; done once.
REQ-033 Default WIDTH=51, CLKDIV=4, word with only bit 0 set -> 50 zeros then 1; cs_n low 408 cycles; 51 rising sclk edges.
REQ-034 valid_in held high, words 0x3C then 0xC3 (WIDTH=8, CLKDIV=2) -> both sent in order; cs_n high exactly 3 cycles between frames.
REQ-035 valid_in pulsed with 0xFF mid-frame of 0x00 -> 0xFF ignored; frame transmits all zeros; ready_out stays 0.
REQ-036 reset_n asserted after 3 rising sclk of a frame -> same-cycle cs_n=1, sclk=0, sdata=0; after release no sclk activity until next handshake.
REQ-037 CLKDIV=1, WIDTH=2, word 2'b10 -> sclk toggles every cycle; cs_n low 4 cycles; sdata 1 then 0.
